osd_him_egress_arb: RTL and testbench
=====================================

OSD_HIM_EGRESS_ARB -- requirements
Module: osd_him_egress_arb

Interface
REQ-001 SHALL have parameter PORTS, default 2: number of DII requesters, 1..8.
REQ-002 SHALL have parameter MAX_LEN, default 31: max payload words per packet, 1..31.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dii_in  dii_channel.slave [PORTS]  16-bit data + valid/ready/first/last  requester packets.
REQ-006 SHALL have port glip_out  glip_channel.master  16  length-prefixed host stream.

Function
REQ-007 SHALL implement FSM IDLE, COLLECT, SEND_LEN, SEND_DATA.
REQ-008 SHALL, in IDLE, grant the lowest port at or after rr_ptr (wrapping) with valid & first; no grant while none qualifies.
REQ-009 SHALL, in IDLE, hold ready=1 on ports with valid & !first and discard those stray words; other ports ready=0.
REQ-010 SHALL accept the granted first word in the IDLE grant cycle, store it at buffer index 0, set count=1, enter COLLECT.
REQ-011 SHALL hold granted-port ready=1 in COLLECT (1 word/cycle), all other ports ready=0.
REQ-012 SHALL store each accepted word at index count, count+1, until a word with last=1; first=1 within a packet treated as data.
REQ-013 SHALL, on attempt to store word MAX_LEN+1, set drop flag, discard all further words through last, return to IDLE with nothing emitted.
REQ-014 SHALL, after last accepted with no drop, enter SEND_LEN next cycle; store-and-forward only.
REQ-015 SHALL in SEND_LEN drive glip_out.valid=1, data = byte-swap of 16-bit count (count in bits 15:8, zero in 7:0).
REQ-016 SHALL in SEND_DATA emit buffered words 0..count-1 in order, each as {word[7:0], word[15:8]}.
REQ-017 SHALL hold glip_out.data stable while valid=1 and ready=0; advance only on valid & ready.
REQ-018 SHALL, after final word handshake, set rr_ptr = granted port + 1 mod PORTS, enter IDLE.
REQ-019 SHALL keep all dii_in ready=0 (except REQ-009 strays in IDLE) during SEND_LEN/SEND_DATA.
REQ-020 SHALL, for single-word packet (first & last together), emit length 1 then one data word.
REQ-021 SHALL drive glip_out.valid=0 outside SEND_LEN/SEND_DATA.

Reset
REQ-022 SHALL on rst low asynchronously force IDLE, rr_ptr=0, count=0, drop=0, glip_out.valid=0, all dii_in ready=0 until first post-reset clock edge.
REQ-023 SHALL on reset mid-packet discard partial/unsent data; no resumption after reset release.
REQ-024 SHALL not reset buffer storage contents.

Configuration
REQ-025 SHALL with OSD_HIM_EGRESS_DROP_CNT_EN defined add output drop_cnt [15:0]: +1 per packet dropped under REQ-013, saturating at 16'hFFFF, reset to 0.
REQ-026 SHALL without OSD_HIM_EGRESS_DROP_CNT_EN have no drop_cnt port/counter; dropping unchanged.

Structure
REQ-027 SHALL place FSM state enum and byte-swap function in shared package osd_him_pkg.
REQ-028 SHALL implement the buffer as sub-module osd_him_pktbuf: MAX_LEN x 16, one write port, one registered-address read port, no reset.

Verification
REQ-029 SHALL test: port0 sends 3 words 16'h0102,0304,0506 -> glip_out 16'h0300,0201,0403,0605.
REQ-030 SHALL test: ports 0,1 both valid&first continuously, 1-word packets -> grants alternate 0,1,0,1; none starved.
REQ-031 SHALL test: 32-word packet with MAX_LEN=31 -> all 32 words accepted, nothing on glip_out, drop_cnt 0->1 when macro defined.
REQ-032 SHALL test: glip_out.ready held 0 for 5 cycles during SEND_DATA -> data stable, no word lost or duplicated.
REQ-033 SHALL test: rst low mid-COLLECT at word 2 of 4 -> IDLE, valid=0; next packet emitted correctly with rr_ptr=0.
REQ-034 SHALL test: port1 valid & !first in IDLE -> word consumed and discarded, no glip_out traffic.

Source files
------------

// File: rtl/osd_him_pkg.sv
// osd_him_pkg: shared FSM state encoding and byte-swap helper for the HIM egress path.
`default_nettype none

package osd_him_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COLLECT   = 2'd1,
    ST_SEND_LEN  = 2'd2,
    ST_SEND_DATA = 2'd3
  } him_state_e;

  function automatic logic [15:0] bswap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/osd_him_pktbuf.sv
// osd_him_pktbuf: DEPTH x 16 packet store, one write port, one registered-address read port.
`default_nettype none

module osd_him_pktbuf
  import osd_him_pkg::*;
#(
  parameter int DEPTH = 31,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] addr_q;

  // Storage and read address are deliberately unreset; the FSM always loads the address before use.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) addr_q <= rd_addr;
  end

  assign rd_data = mem[addr_q];

endmodule

`default_nettype wire

// File: rtl/osd_him_egress_arb.sv
// osd_him_egress_arb: round-robin DII packet arbiter, store-and-forward to a length-prefixed GLIP stream.
// Optional drop counter output enabled by defining OSD_HIM_EGRESS_DROP_CNT_EN.
`default_nettype none

module osd_him_egress_arb
  import osd_him_pkg::*;
#(
  parameter int PORTS   = 2,
  parameter int MAX_LEN = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0][15:0] dii_in_data,
  input  logic [PORTS-1:0]       dii_in_valid,
  input  logic [PORTS-1:0]       dii_in_first,
  input  logic [PORTS-1:0]       dii_in_last,
  output logic [PORTS-1:0]       dii_in_ready,
  output logic [15:0]            glip_out_data,
  output logic                   glip_out_valid,
  input  logic                   glip_out_ready
`ifdef OSD_HIM_EGRESS_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  him_state_e    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt;
  logic [CW-1:0] count;
  logic [CW-1:0] send_idx;
  logic          drop;

  logic          found;
  logic [PW-1:0] sel;
  logic          word_in;
  logic          buf_full;
  logic          last_word;
  logic          wr_en;
  logic [CW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          rd_en;
  logic [CW-1:0] rd_addr;
  logic [15:0]   rd_data;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % PORTS;
      if (!found && dii_in_valid[idx] && dii_in_first[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  assign word_in   = (state == ST_COLLECT) && dii_in_valid[gnt];
  assign buf_full  = (count == CW'(MAX_LEN));
  assign last_word = (send_idx == count - CW'(1));

  always_comb begin
    dii_in_ready = '0;
    if (state == ST_IDLE) begin
      dii_in_ready = dii_in_valid & ~dii_in_first;
      if (found) dii_in_ready[sel] = 1'b1;
    end else if (state == ST_COLLECT) begin
      dii_in_ready[gnt] = 1'b1;
    end
    if (!rst) dii_in_ready = '0;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = count;
    wr_data = dii_in_data[gnt];
    if (state == ST_IDLE) begin
      wr_en   = found;
      wr_addr = '0;
      wr_data = dii_in_data[sel];
    end else if (word_in && !drop && !buf_full) begin
      wr_en = 1'b1;
    end
  end

  // Address loads on each handshake so the next word is presented the following cycle.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = send_idx + CW'(1);
    if (state == ST_SEND_LEN) begin
      rd_en   = glip_out_ready;
      rd_addr = '0;
    end else if (state == ST_SEND_DATA) begin
      rd_en = glip_out_ready && !last_word;
    end
  end

  always_comb begin
    glip_out_valid = (state == ST_SEND_LEN) || (state == ST_SEND_DATA);
    glip_out_data  = '0;
    if (state == ST_SEND_LEN)
      glip_out_data = bswap16(16'(count));
    else if (state == ST_SEND_DATA)
      glip_out_data = bswap16(rd_data);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      count    <= '0;
      send_idx <= '0;
      drop     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          drop <= 1'b0;
          if (found) begin
            gnt   <= sel;
            count <= CW'(1);
            state <= dii_in_last[sel] ? ST_SEND_LEN : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (word_in) begin
            if (drop || buf_full) begin
              drop <= 1'b1;
              if (dii_in_last[gnt]) state <= ST_IDLE;
            end else begin
              count <= count + CW'(1);
              if (dii_in_last[gnt]) state <= ST_SEND_LEN;
            end
          end
        end
        ST_SEND_LEN: begin
          if (glip_out_ready) begin
            send_idx <= '0;
            state    <= ST_SEND_DATA;
          end
        end
        ST_SEND_DATA: begin
          if (glip_out_ready) begin
            if (last_word) begin
              state  <= ST_IDLE;
              rr_ptr <= (gnt == PW'(PORTS - 1)) ? '0 : gnt + PW'(1);
            end else begin
              send_idx <= send_idx + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef OSD_HIM_EGRESS_DROP_CNT_EN
  logic drop_hit;
  assign drop_hit = word_in && !drop && buf_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if (drop_hit && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end
`else
  // Oversized packets are still discarded; only the statistic is absent.
`endif

  osd_him_pktbuf #(
    .DEPTH (MAX_LEN),
    .AW    (CW)
  ) u_pktbuf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_osd_him_egress_arb.sv
// tb_osd_him_egress_arb: directed vector table plus hand-written multi-cycle sequences.
`default_nettype none

module tb_osd_him_egress_arb;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0][15:0] d;
  logic [1:0]      v, f, l, rdy;
  logic [15:0]     gd;
  logic            gv, gr;
`ifdef OSD_HIM_EGRESS_DROP_CNT_EN
  logic [15:0]     drop_cnt;
`endif

  always #5 clk = ~clk;

  osd_him_egress_arb #(.PORTS(2), .MAX_LEN(31)) dut (
    .clk            (clk),
    .rst            (rst),
    .dii_in_data    (d),
    .dii_in_valid   (v),
    .dii_in_first   (f),
    .dii_in_last    (l),
    .dii_in_ready   (rdy),
    .glip_out_data  (gd),
    .glip_out_valid (gv),
    .glip_out_ready (gr)
`ifdef OSD_HIM_EGRESS_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  v, f, l;
    logic [15:0] d0, d1;
    logic        gr;
    logic [1:0]  er;
    logic        egv;
    logic [15:0] egd;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_w [32];
  vec_t        vecs [24];

  function automatic vec_t mk(input logic [1:0] vv, ff, ll, input logic [15:0] d0, d1,
                              input logic [1:0] er, input logic egv, input logic [15:0] egd);
    vec_t x;
    x.v = vv; x.f = ff; x.l = ll; x.d0 = d0; x.d1 = d1; x.gr = 1'b1;
    x.er = er; x.egv = egv; x.egd = egd;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setin(input logic [1:0] vv, ff, ll, input logic [15:0] d0, d1, input logic g);
    v = vv; f = ff; l = ll; d[0] = d0; d[1] = d1; gr = g;
  endtask

  // Inputs are applied 1 time unit after posedge; outputs are checked 2 units later.
  task automatic step(input string nm, input logic [1:0] er, input logic egv, input logic [15:0] egd);
    #2;
    chk({nm, "_rdy"}, 16'(rdy), 16'(er));
    chk({nm, "_gv"}, 16'(gv), 16'(egv));
    if (egv) chk({nm, "_gd"}, gd, egd);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input string nm, input int port, input int n);
    logic [1:0] m;
    m = '0;
    m[port] = 1'b1;
    for (int k = 0; k < n; k++) begin
      setin(m, (k == 0) ? m : 2'b00, (k == n - 1) ? m : 2'b00, exp_w[k], exp_w[k], 1'b1);
      step($sformatf("%s_w%0d", nm, k), m, 1'b0, 16'h0);
    end
  endtask

  task automatic drain(input string nm, input int n);
    logic [15:0] lw;
    lw = 16'(n) << 8;
    setin(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1);
    step({nm, "_len"}, 2'b00, 1'b1, lw);
    for (int k = 0; k < n; k++)
      step($sformatf("%s_d%0d", nm, k), 2'b00, 1'b1, {exp_w[k][7:0], exp_w[k][15:8]});
    step({nm, "_end"}, 2'b00, 1'b0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Port 0 three-word packet, then a stray word, then continuous contention.
    vecs[0]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000);
    vecs[1]  = mk(2'b01, 2'b01, 2'b00, 16'h0102, 16'h0000, 2'b01, 1'b0, 16'h0000);
    vecs[2]  = mk(2'b01, 2'b00, 2'b00, 16'h0304, 16'h0000, 2'b01, 1'b0, 16'h0000);
    vecs[3]  = mk(2'b01, 2'b00, 2'b01, 16'h0506, 16'h0000, 2'b01, 1'b0, 16'h0000);
    vecs[4]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0300);
    vecs[5]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0201);
    vecs[6]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0403);
    vecs[7]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0605);
    vecs[8]  = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000);
    vecs[9]  = mk(2'b10, 2'b00, 2'b00, 16'h0000, 16'hBEEF, 2'b10, 1'b0, 16'h0000);
    vecs[10] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000);
    vecs[11] = mk(2'b11, 2'b11, 2'b11, 16'hA1B2, 16'hC3D4, 2'b10, 1'b0, 16'h0000);
    vecs[12] = mk(2'b11, 2'b11, 2'b11, 16'hA1B2, 16'hC3D4, 2'b00, 1'b1, 16'h0100);
    vecs[13] = mk(2'b11, 2'b11, 2'b11, 16'hA1B2, 16'hC3D4, 2'b00, 1'b1, 16'hD4C3);
    vecs[14] = mk(2'b11, 2'b11, 2'b11, 16'hA1B2, 16'hC3D4, 2'b01, 1'b0, 16'h0000);
    vecs[15] = mk(2'b11, 2'b11, 2'b11, 16'hA1B2, 16'hC3D4, 2'b00, 1'b1, 16'h0100);
    vecs[16] = mk(2'b11, 2'b11, 2'b11, 16'hA1B2, 16'hC3D4, 2'b00, 1'b1, 16'hB2A1);
    vecs[17] = mk(2'b11, 2'b11, 2'b11, 16'hA1B2, 16'hC3D4, 2'b10, 1'b0, 16'h0000);
    vecs[18] = mk(2'b11, 2'b11, 2'b11, 16'hA1B2, 16'hC3D4, 2'b00, 1'b1, 16'h0100);
    vecs[19] = mk(2'b11, 2'b11, 2'b11, 16'hA1B2, 16'hC3D4, 2'b00, 1'b1, 16'hD4C3);
    vecs[20] = mk(2'b11, 2'b11, 2'b11, 16'hA1B2, 16'hC3D4, 2'b01, 1'b0, 16'h0000);
    vecs[21] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0100);
    vecs[22] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'hB2A1);
    vecs[23] = mk(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000);

    // Reset state, with a stray word presented that must not be accepted while in reset.
    setin(2'b10, 2'b00, 2'b00, 16'h0, 16'h1234, 1'b1);
    @(posedge clk);
    #1;
    step("reset", 2'b00, 1'b0, 16'h0);
`ifdef OSD_HIM_EGRESS_DROP_CNT_EN
    chk("reset_drop_cnt", drop_cnt, 16'h0000);
`endif
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      setin(vecs[i].v, vecs[i].f, vecs[i].l, vecs[i].d0, vecs[i].d1, vecs[i].gr);
      step($sformatf("vec%0d", i), vecs[i].er, vecs[i].egv, vecs[i].egd);
    end

    // 32-word packet on port 0: every word accepted, nothing emitted.
    for (int k = 0; k < 32; k++) exp_w[k] = 16'h1000 + 16'(k);
    send_pkt("drop", 0, 32);
    setin(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1);
    for (int k = 0; k < 3; k++) step("drop_quiet", 2'b00, 1'b0, 16'h0);
`ifdef OSD_HIM_EGRESS_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, 16'h0001);
`endif

    // Largest legal packet.
    for (int k = 0; k < 31; k++) exp_w[k] = 16'h1200 + 16'(k * 257);
    send_pkt("max", 0, 31);
    drain("max", 31);

    // Output stall on port 1 packet mid SEND_DATA.
    exp_w[0] = 16'h0A0B; exp_w[1] = 16'h0C0D; exp_w[2] = 16'h0E0F;
    send_pkt("stall", 1, 3);
    setin(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1);
    step("stall_len", 2'b00, 1'b1, 16'h0300);
    step("stall_d0", 2'b00, 1'b1, 16'h0B0A);
    for (int k = 0; k < 5; k++) begin
      setin(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0);
      step($sformatf("stall_hold%0d", k), 2'b00, 1'b1, 16'h0D0C);
    end
    setin(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1);
    step("stall_d1", 2'b00, 1'b1, 16'h0D0C);
    step("stall_d2", 2'b00, 1'b1, 16'h0F0E);
    step("stall_end", 2'b00, 1'b0, 16'h0);

    // Move rr_ptr to 1, then reset in the middle of a port 1 packet.
    exp_w[0] = 16'h5A5A;
    send_pkt("pre", 0, 1);
    drain("pre", 1);
    exp_w[0] = 16'h7001; exp_w[1] = 16'h7002;
    setin(2'b10, 2'b10, 2'b00, 16'h0, exp_w[0], 1'b1);
    step("mid_w0", 2'b10, 1'b0, 16'h0);
    setin(2'b10, 2'b00, 2'b00, 16'h0, exp_w[1], 1'b1);
    step("mid_w1", 2'b10, 1'b0, 16'h0);
    setin(2'b10, 2'b00, 2'b00, 16'h0, 16'h7003, 1'b1);
    rst = 1'b0;
    step("mid_rst", 2'b00, 1'b0, 16'h0);
    setin(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1);
    step("mid_rst_hold", 2'b00, 1'b0, 16'h0);
    rst = 1'b1;
    step("post_rst_idle", 2'b00, 1'b0, 16'h0);
    setin(2'b11, 2'b11, 2'b11, 16'h1357, 16'h2468, 1'b1);
    step("post_rst_gnt", 2'b01, 1'b0, 16'h0);
    exp_w[0] = 16'h1357;
    drain("post_rst", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
